neuron_mac_engine: RTL and testbench
====================================

# neuron_mac_engine

Downstream consumer of the weight SRAM: evaluates one MLP neuron by streaming INPUT_NUM activations, fetching the matching weight from SRAM per activation, and computing a signed fixed-point multiply-accumulate plus bias. It then saturates the result and presents it on a valid/ready output port. It drives the SRAM read port directly. That port is combinational, so read data is valid in the same cycle as the address.

## Interface
- WEIGHT_WIDTH, 32: width of weights, activations, bias and output; signed two's complement.
- INPUT_NUM, 8: inputs per neuron (≥1); equals the number of SRAM entries used.
- ADDR_WIDTH, 8: SRAM address width; must be ≥ $clog2(INPUT_NUM).
- FRAC_BITS, 16: fractional bits of the fixed-point format (0 ≤ FRAC_BITS < WEIGHT_WIDTH).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request evaluation; accepted only in IDLE.
- bias  in  WEIGHT_WIDTH  sampled on the cycle start is accepted.
- busy  out  1  high in every state except IDLE.
- x_valid  in  1  activation available.
- x_data  in  WEIGHT_WIDTH  activation, in address order 0..INPUT_NUM-1.
- x_ready  out  1  engine accepts an activation.
- mem_read_enable  out  1  SRAM read enable.
- mem_read_address  out  ADDR_WIDTH  SRAM read address.
- mem_read_data  in  WEIGHT_WIDTH  SRAM weight; combinational from address.
- out_valid  out  1  result available.
- out_data  out  WEIGHT_WIDTH  neuron result.
- out_ready  in  1  downstream accepts result.

## Operation
- FSM states: IDLE, FETCH, DRAIN, ROUND, OUTPUT.
- IDLE:
  - Outputs at reset values.
  - start=1 → FETCH; idx←0, acc←bias<<<FRAC_BITS (sign-extended), prod_vld←0.
- FETCH:
  - x_ready=1, mem_read_enable=1, mem_read_address=idx (registered).
  - Accept when x_valid&x_ready: prod←x_data*mem_read_data (signed, 2*WEIGHT_WIDTH bits), prod_vld←1, idx←idx+1.
  - No accept: prod_vld←0.
  - Every cycle: if prod_vld then acc←acc+prod.
  - The accept with idx==INPUT_NUM-1 → DRAIN.
- DRAIN: x_ready=0, mem_read_enable=0; adds the final prod to acc → ROUND.
- ROUND:
  - Computes r = acc>>>FRAC_BITS (arithmetic shift, floor).
  - Saturates r to [−2^(WEIGHT_WIDTH−1), 2^(WEIGHT_WIDTH−1)−1] and registers it into out_data → OUTPUT.
- OUTPUT:
  - out_valid=1; out_data held stable.
  - out_valid&out_ready → IDLE, out_valid←0, out_data keeps its value.
- Accumulator width: 2*WEIGHT_WIDTH+$clog2(INPUT_NUM)+1 bits; no internal overflow possible.
- start while busy is ignored, including in the OUTPUT handshake cycle.
- x_valid outside FETCH is never consumed (x_ready=0).
- mem_read_address=0 whenever not in FETCH.

## Timing
- Reset values: busy=0, x_ready=0, mem_read_enable=0, mem_read_address=0, out_valid=0, out_data=0. Internal idx, acc, prod and prod_vld are cleared.
- Reset mid-operation (any state) → IDLE next cycle with reset values; a partial accumulation is discarded.
- start accepted at edge 0: FETCH in cycles 1..N when x_valid is held high (N=INPUT_NUM), DRAIN in cycle N+1, ROUND in cycle N+2, out_valid=1 in cycle N+3.
- Each x_valid gap cycle extends the latency by one cycle.
- Throughput: one activation per cycle in FETCH; minimum one IDLE cycle between results.
- mem_read_address changes only on an accept edge; the weight is sampled in the same cycle as x_data.

## Configuration
- NEURON_RELU_EN defined: ReLU is applied in ROUND after saturation; a negative r gives out_data=0.
- Not defined: the saturated r is output unchanged, and negative results pass through.

## Test plan
All scenarios use WEIGHT_WIDTH=32, FRAC_BITS=16, INPUT_NUM=4.
- Basic:
  - Weights all 0x00010000; x=1,2,3,4 (0x00010000..0x00040000); bias 0x00008000; x_valid held high.
  - out_data=0x000A8000; out_valid rises exactly 7 cycles after start; mem_read_address sequence 0,1,2,3.
- Negative:
  - Weights 0xFFFF0000; same x; bias 0.
  - Without NEURON_RELU_EN, out_data=0xFFF60000; with it, out_data=0x00000000.
- Saturation:
  - Weights and x all 0x7FFF0000; bias 0 → out_data=0x7FFFFFFF.
  - Weights 0x80000000; x 0x7FFF0000 → 0x80000000 (0 with RELU).
- Stalls:
  - Basic vectors with 2 idle x_valid cycles between inputs → same 0x000A8000; out_valid 13 cycles after start (7 + 6 gap cycles); no activation consumed twice.
- Backpressure:
  - out_ready low for 5 cycles in OUTPUT → out_valid and out_data stable.
  - start pulses during this time ignored; busy stays 1; IDLE one cycle after out_ready=1.
- Reset mid-FETCH:
  - rst after 2 accepts → all outputs at reset values next cycle.
  - A fresh Basic run then yields exactly 0x000A8000, with no residue.

Source files
------------

// File: rtl/neuron_mac_engine.sv
// neuron_mac_engine: one MLP neuron. It streams INPUT_NUM activations, fetches
// the matching weight from the SRAM for each one, multiply-accumulates them on
// top of the bias, then floors to the fixed-point grid, saturates, and presents
// the result on a valid/ready port.
// Optional build macro NEURON_RELU_EN: when defined, a ReLU is applied after
// saturation.
module neuron_mac_engine #(
   parameter int WEIGHT_WIDTH = 32,
   parameter int INPUT_NUM    = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int FRAC_BITS    = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [WEIGHT_WIDTH-1:0] bias,
   output logic                    busy,
   input  logic                    x_valid,
   input  logic [WEIGHT_WIDTH-1:0] x_data,
   output logic                    x_ready,
   output logic                    mem_read_enable,
   output logic [ADDR_WIDTH-1:0]   mem_read_address,
   input  logic [WEIGHT_WIDTH-1:0] mem_read_data,
   output logic                    out_valid,
   output logic [WEIGHT_WIDTH-1:0] out_data,
   input  logic                    out_ready
);

   localparam int PROD_W = 2 * WEIGHT_WIDTH;
   // Headroom for INPUT_NUM products plus the shifted bias, so the sum cannot wrap.
   localparam int ACC_W  = PROD_W + $clog2(INPUT_NUM) + 1;
   localparam logic [ADDR_WIDTH-1:0] IDX_LAST = ADDR_WIDTH'(INPUT_NUM - 1);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] FETCH  = 3'd1;
   localparam logic [2:0] DRAIN  = 3'd2;
   localparam logic [2:0] ROUND  = 3'd3;
   localparam logic [2:0] OUTPUT = 3'd4;

   logic [2:0]                     state;
   logic [ADDR_WIDTH-1:0]          idx;
   logic                           accept;
   logic signed [WEIGHT_WIDTH-1:0] x_s;
   logic signed [WEIGHT_WIDTH-1:0] w_s;
   logic signed [WEIGHT_WIDTH-1:0] bias_s;
   logic signed [PROD_W-1:0]       prod_p1;
   logic                           vld_p1;
   logic signed [ACC_W-1:0]        acc_p2;
   logic signed [ACC_W-1:0]        acc_sum;
   logic signed [WEIGHT_WIDTH-1:0] out_q;

   // Floor to the integer grid (an arithmetic shift rounds toward -inf), then
   // clamp to the output range. The value fits only when every bit above the
   // output sign bit matches that sign bit.
   function automatic logic signed [WEIGHT_WIDTH-1:0] round_sat(input logic signed [ACC_W-1:0] a);
      logic signed [ACC_W-1:0]      r;
      logic [ACC_W-WEIGHT_WIDTH:0]  hi;
      r  = a >>> FRAC_BITS;
      hi = r[ACC_W-1:WEIGHT_WIDTH-1];
      if ((&hi) || !(|hi))
         return r[WEIGHT_WIDTH-1:0];
      else if (r[ACC_W-1])
         return {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};
      else
         return {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
   endfunction

   // Optional rectifier applied after saturation.
   function automatic logic signed [WEIGHT_WIDTH-1:0] relu(input logic signed [WEIGHT_WIDTH-1:0] s);
`ifdef NEURON_RELU_EN
      return s[WEIGHT_WIDTH-1] ? '0 : s;
`else
      return s;
`endif
   endfunction

   assign x_s     = x_data;
   assign w_s     = mem_read_data;
   assign bias_s  = bias;
   assign accept  = x_valid && (state == FETCH);
   assign acc_sum = acc_p2 + ACC_W'(prod_p1);

   assign busy             = (state != IDLE);
   assign x_ready          = (state == FETCH);
   assign mem_read_enable  = (state == FETCH);
   assign mem_read_address = (state == FETCH) ? idx : '0;
   assign out_valid        = (state == OUTPUT);
   assign out_data         = out_q;

   // Control FSM: sequences fetch, accumulator drain, rounding and the output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (start) state <= FETCH;
            FETCH:   if (accept && (idx == IDX_LAST)) state <= DRAIN;
            DRAIN:   state <= ROUND;
            ROUND:   state <= OUTPUT;
            OUTPUT:  if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Activation index: it doubles as the SRAM address and advances only on an accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx <= '0;
      end else if (state == IDLE) begin
         if (start) idx <= '0;
      end else if (accept) begin
         idx <= idx + ADDR_WIDTH'(1);
      end
   end

   // Stage p1: register the activation * weight product together with its valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         prod_p1 <= '0;
         vld_p1  <= 1'b0;
      end else if (accept) begin
         prod_p1 <= PROD_W'(x_s) * PROD_W'(w_s);
         vld_p1  <= 1'b1;
      end else begin
         vld_p1  <= 1'b0;
      end
   end

   // Stage p2: the accumulator is seeded with the bias scaled into the product format.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p2 <= '0;
      end else if ((state == IDLE) && start) begin
         acc_p2 <= ACC_W'(bias_s) <<< FRAC_BITS;
      end else if (((state == FETCH) || (state == DRAIN)) && vld_p1) begin
         acc_p2 <= acc_sum;
      end
   end

   // Result register: loaded once in ROUND and held through OUTPUT and the following IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q <= '0;
      end else if (state == ROUND) begin
         out_q <= relu(round_sat(acc_p2));
      end
   end

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Testbench for neuron_mac_engine (WEIGHT_WIDTH=32, FRAC_BITS=16, INPUT_NUM=4).
// The bench models the SRAM as a small array. A reference model computes each
// result from the activations actually consumed, and directed runs pin the
// hand-computed values.
module tb_neuron_mac_engine;

   localparam int W    = 32;
   localparam int N    = 4;
   localparam int AW   = 8;
   localparam int FRAC = 16;

   localparam logic signed [127:0] MAXV = 128'sh7FFFFFFF;
   localparam logic signed [127:0] MINV = -128'sh80000000;

`ifdef NEURON_RELU_EN
   localparam logic [31:0] NEG_EXP     = 32'h00000000;
   localparam logic [31:0] SAT_NEG_EXP = 32'h00000000;
`else
   localparam logic [31:0] NEG_EXP     = 32'hFFF60000;
   localparam logic [31:0] SAT_NEG_EXP = 32'h80000000;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  bias;
   logic          busy;
   logic          x_valid;
   logic [W-1:0]  x_data;
   logic          x_ready;
   logic          mem_read_enable;
   logic [AW-1:0] mem_read_address;
   logic [W-1:0]  mem_read_data;
   logic          out_valid;
   logic [W-1:0]  out_data;
   logic          out_ready;

   logic [W-1:0]  mem    [N];
   logic [W-1:0]  stim_x [N];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // reference-model state, captured from the handshakes the DUT performs
   logic [W-1:0] m_bias;
   logic [W-1:0] m_xs [$];
   logic [W-1:0] m_ws [$];
   logic         p_hold = 1'b0;
   logic [W-1:0] p_data = '0;

   neuron_mac_engine #(
      .WEIGHT_WIDTH(W),
      .INPUT_NUM(N),
      .ADDR_WIDTH(AW),
      .FRAC_BITS(FRAC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .bias(bias),
      .busy(busy),
      .x_valid(x_valid),
      .x_data(x_data),
      .x_ready(x_ready),
      .mem_read_enable(mem_read_enable),
      .mem_read_address(mem_read_address),
      .mem_read_data(mem_read_data),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign mem_read_data = (mem_read_address < AW'(N)) ? mem[mem_read_address[1:0]] : '0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   function automatic logic signed [127:0] sx(input logic [31:0] v);
      return $signed({{96{v[31]}}, v});
   endfunction

   // Exact rational result: (bias*2^F + sum x*w) / 2^F, floored, clamped, optionally rectified.
   function automatic logic [31:0] model_out();
      logic signed [127:0] t;
      logic signed [127:0] r;
      t = sx(m_bias) * 128'sd65536;
      foreach (m_xs[i]) t = t + sx(m_xs[i]) * sx(m_ws[i]);
      r = t >>> FRAC;
      if (r > MAXV) r = MAXV;
      else if (r < MINV) r = MINV;
`ifdef NEURON_RELU_EN
      if (r < 0) r = 0;
`endif
      return r[31:0];
   endfunction

   // Compare process: checks address/enable, consumption order, result and hold stability every cycle.
   always @(negedge clk) begin
      if (rst) begin
         m_xs.delete();
         m_ws.delete();
         p_hold = 1'b0;
      end else begin
         if (p_hold) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_data", 64'(out_data), 64'(p_data));
         end
         if (!x_ready) begin
            chk("addr_zero_outside_fetch", 64'(mem_read_address), 64'd0);
            chk("ren_low_outside_fetch", 64'(mem_read_enable), 64'd0);
         end
         if (start && !busy) begin
            m_bias = bias;
            m_xs.delete();
            m_ws.delete();
         end
         if (x_valid && x_ready) begin
            chk("addr_seq", 64'(mem_read_address), 64'(m_xs.size()));
            chk("ren_in_fetch", 64'(mem_read_enable), 64'd1);
            m_ws.push_back((m_xs.size() < N) ? mem[m_xs.size()] : 32'h0);
            m_xs.push_back(x_data);
         end
         if (out_valid && out_ready) begin
            chk("consumed_count", 64'(m_xs.size()), 64'(N));
            chk("model_out", 64'(out_data), 64'(model_out()));
         end
         p_hold = out_valid && !out_ready;
         p_data = out_data;
      end
   end

   task automatic send_x(input logic [31:0] v);
      int t;
      t = 0;
      x_valid = 1'b1;
      x_data  = v;
      @(negedge clk);
      while (!x_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (t >= 50) chk("x_ready_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      x_valid = 1'b0;
      x_data  = 32'hDEADBEEF;
   endtask

   task automatic do_run(input string nm, input logic [31:0] b, input int gap, input int hold,
                         input logic [31:0] exp, input int exp_lat);
      int c0;
      int t;
      @(posedge clk);
      #1;
      start = 1'b1;
      bias  = b;
      @(negedge clk);
      chk({nm, "_busy_before"}, 64'(busy), 64'd0);
      c0 = cyc;
      @(posedge clk);
      #1;
      start = 1'b0;
      bias  = 32'h12345678;
      for (int i = 0; i < N; i++) begin
         if (i > 0 && gap > 0) begin
            repeat (gap) @(posedge clk);
            #1;
         end
         send_x(stim_x[i]);
      end
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (t >= 100) chk({nm, "_out_valid_timeout"}, 64'd0, 64'd1);
      chk({nm, "_latency"}, 64'(cyc - c0), 64'(exp_lat));
      for (int k = 0; k < hold; k++) begin
         chk({nm, "_bp_busy"}, 64'(busy), 64'd1);
         chk({nm, "_bp_valid"}, 64'(out_valid), 64'd1);
         chk({nm, "_bp_data"}, 64'(out_data), 64'(exp));
         @(posedge clk);
         #1;
         start = ~start;
         if (k == hold - 1) begin
            out_ready = 1'b1;
            start     = 1'b1;
         end
         @(negedge clk);
      end
      chk({nm, "_valid"}, 64'(out_valid), 64'd1);
      chk({nm, "_data"}, 64'(out_data), 64'(exp));
      @(posedge clk);
      #1;
      start     = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk({nm, "_idle_busy"}, 64'(busy), 64'd0);
      chk({nm, "_idle_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "_data_kept"}, 64'(out_data), 64'(exp));
   endtask

   task automatic check_reset_outputs(input string nm);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
      chk({nm, "_x_ready"}, 64'(x_ready), 64'd0);
      chk({nm, "_ren"}, 64'(mem_read_enable), 64'd0);
      chk({nm, "_addr"}, 64'(mem_read_address), 64'd0);
      chk({nm, "_out_valid"}, 64'(out_valid), 64'd0);
      chk({nm, "_out_data"}, 64'(out_data), 64'd0);
   endtask

   task automatic load_basic();
      for (int i = 0; i < N; i++) begin
         mem[i]    = 32'h00010000;
         stim_x[i] = 32'h00010000 * (i + 1);
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      bias      = '0;
      x_valid   = 1'b0;
      x_data    = '0;
      out_ready = 1'b1;
      load_basic();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // basic: 1+2+3+4 plus a bias of 0.5 gives 10.5
      do_run("basic", 32'h00008000, 0, 0, 32'h000A8000, 7);

      // negative weights: -10.0
      for (int i = 0; i < N; i++) mem[i] = 32'hFFFF0000;
      do_run("negative", 32'h0, 0, 0, NEG_EXP, 7);

      // positive saturation: 4 * 32767^2 is far above the maximum
      for (int i = 0; i < N; i++) begin
         mem[i]    = 32'h7FFF0000;
         stim_x[i] = 32'h7FFF0000;
      end
      do_run("sat_pos", 32'h0, 0, 0, 32'h7FFFFFFF, 7);

      // negative saturation: weight of -32768.0
      for (int i = 0; i < N; i++) mem[i] = 32'h80000000;
      do_run("sat_neg", 32'h0, 0, 0, SAT_NEG_EXP, 7);

      // stalls: two idle x_valid cycles between inputs adds six cycles
      load_basic();
      do_run("stall", 32'h00008000, 2, 0, 32'h000A8000, 13);

      // backpressure: five cycles of out_ready low, with start pulses that must be ignored
      out_ready = 1'b0;
      do_run("backpressure", 32'h00008000, 0, 5, 32'h000A8000, 7);

      // reset mid-FETCH after two accepts
      @(posedge clk);
      #1;
      start = 1'b1;
      bias  = 32'h00008000;
      @(posedge clk);
      #1;
      start = 1'b0;
      send_x(stim_x[0]);
      send_x(stim_x[1]);
      @(negedge clk);
      chk("midfetch_busy", 64'(busy), 64'd1);
      chk("midfetch_addr", 64'(mem_read_address), 64'd2);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("midfetch_reset");
      do_run("after_reset", 32'h00008000, 0, 0, 32'h000A8000, 7);

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
